// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register datapath.
//   - Operation codes carried on the 3-bit mode bus.
//   - FSM state type used by the top-level controller.
//   - Helper that classifies a mode code as a single-bit shift/rotate.
package shift_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] HOLD = 3'd0;
  localparam logic [MODE_W-1:0] LOAD = 3'd1;
  localparam logic [MODE_W-1:0] SHL  = 3'd2;
  localparam logic [MODE_W-1:0] SHR  = 3'd3;
  localparam logic [MODE_W-1:0] ROL  = 3'd4;
  localparam logic [MODE_W-1:0] ROR  = 3'd5;
  localparam logic [MODE_W-1:0] ASR  = 3'd6;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // True for the codes that move bits; HOLD, LOAD and reserved codes are not shifts.
  function automatic logic is_shift_mode(input logic [MODE_W-1:0] mode);
    return (mode == SHL) || (mode == SHR) || (mode == ROL) ||
           (mode == ROR) || (mode == ASR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-step shift/rotate network (purely combinational).
// Ports:
//   mode     : latched operation code
//   q        : current register contents
//   sin      : serial fill bit for SHL/SHR
//   q_nxt    : register contents after one step
//   sout_nxt : bit ejected by that step
// Non-shift codes pass q through unchanged; the caller only uses the
// result while an operation is in progress.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  q,
  input  logic              sin,
  output logic [WIDTH-1:0]  q_nxt,
  output logic              sout_nxt
);

  always_comb begin
    // NOTE: default every output first so no path through the case infers a latch.
    q_nxt    = q;
    sout_nxt = 1'b0;
    case (mode)
      SHL: begin
        q_nxt    = {q[WIDTH-2:0], sin};
        sout_nxt = q[WIDTH-1];
      end
      SHR: begin
        q_nxt    = {sin, q[WIDTH-1:1]};
        sout_nxt = q[0];
      end
      ROL: begin
        q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
        sout_nxt = q[WIDTH-1];
      end
      ROR: begin
        q_nxt    = {q[0], q[WIDTH-1:1]};
        sout_nxt = q[0];
      end
      ASR: begin
        q_nxt    = {q[WIDTH-1], q[WIDTH-1:1]};
        sout_nxt = q[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/param_shift_reg.sv
// Parametrised universal shift register with a start/busy/done handshake.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   clr        : synchronous clear, aborts any operation, wins over start
//   start      : operation request, honoured only in IDLE
//   mode       : operation code (shift_pkg)
//   amount     : number of single-bit steps (clamped to WIDTH)
//   d          : parallel load data
//   sin        : serial fill bit, sampled every shift cycle
//   q          : register contents
//   sout       : bit ejected by the most recent shift/rotate
//   busy       : high while in SHIFT
//   done       : one-cycle completion pulse
module param_shift_reg
  import shift_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               AMT_W     = $clog2(WIDTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              start,
  input  logic [MODE_W-1:0] mode,
  input  logic [AMT_W-1:0]  amount,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin,
  output logic [WIDTH-1:0]  q,
  output logic              sout,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [AMT_W-1:0]  cnt;
  logic [MODE_W-1:0] mode_q;
  logic [WIDTH-1:0]  step_q;
  logic              step_sout;
  logic [AMT_W-1:0]  amt_clamped;

  // Amounts above WIDTH would only repeat work already done by WIDTH steps.
  assign amt_clamped = (amount > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amount;

  // busy is a pure decode of the registered state, so it has no extra latency.
  assign busy = (state == SHIFT);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .mode     (mode_q),
    .q        (q),
    .sin      (sin),
    .q_nxt    (step_q),
    .sout_nxt (step_sout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every control register is reset, including the latched mode
      // and count, so an aborted operation leaves nothing behind.
      state  <= IDLE;
      q      <= RESET_VAL;
      sout   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      mode_q <= HOLD;
    end else if (clr) begin
      state  <= IDLE;
      q      <= RESET_VAL;
      sout   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      mode_q <= HOLD;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (mode == LOAD) begin
              q    <= d;
              done <= 1'b1;
            end else if (is_shift_mode(mode) && (amount != '0)) begin
              mode_q <= mode;
              cnt    <= amt_clamped;
              state  <= SHIFT;
            end else begin
              // HOLD, reserved codes and zero-length shifts complete at once.
              done <= 1'b1;
            end
          end
        end
        SHIFT: begin
          q    <= step_q;
          sout <= step_sout;
          cnt  <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_shift_reg.sv
// Self-checking bench for param_shift_reg (WIDTH=8): a table of directed
// load-then-operate vectors plus hand-written reset/clear/busy sequences.
module tb_param_shift_reg;
  import shift_pkg::*;

  localparam int WIDTH = 8;
  localparam int AMT_W = $clog2(WIDTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic              start;
  logic [MODE_W-1:0] mode;
  logic [AMT_W-1:0]  amount;
  logic [WIDTH-1:0]  d;
  logic              sin;
  logic [WIDTH-1:0]  q;
  logic              sout;
  logic              busy;
  logic              done;

  int n_cmp  = 0;
  int n_fail = 0;

  param_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(8'h00)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .start  (start),
    .mode   (mode),
    .amount (amount),
    .d      (d),
    .sin    (sin),
    .q      (q),
    .sout   (sout),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // done and busy must never be high together.
  always @(negedge clk) begin
    if (rst_n && (busy || done)) check("done_busy_excl", {31'd0, busy & done}, 32'd0);
  end

  typedef struct {
    logic [7:0]        init_q;
    logic [MODE_W-1:0] op;
    logic [AMT_W-1:0]  amt;
    logic              s;
    logic [7:0]        exp_q;
    logic              chk_sout;
    logic              exp_sout;
    int                exp_lat;
  } vec_t;

  // Issue one operation; report cycles from the start edge to done and the
  // number of busy cycles seen. poke re-asserts start (as a LOAD) mid-shift.
  task automatic run_op(input logic [MODE_W-1:0] m, input logic [AMT_W-1:0] a,
                        input logic s, input logic [7:0] dd, input logic poke,
                        output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; mode = m; amount = a; sin = s; d = dd;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (poke && lat == 1) begin
        @(negedge clk);
        start = 1'b1; mode = LOAD; d = 8'hFF; amount = 4'd2;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
  endtask

  task automatic load(input logic [7:0] v);
    int lat, bcnt;
    run_op(LOAD, 4'd0, 1'b0, v, 1'b0, lat, bcnt);
    check("load_q", {24'd0, q}, {24'd0, v});
    check("load_lat", lat, 1);
    check("load_busy", bcnt, 0);
    @(posedge clk); #1;
    check("load_done_pulse", {31'd0, done}, 32'd0);
  endtask

  // Watch a quiet window and count any done pulses.
  task automatic quiet_window(input string name);
    int pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check(name, pulses, 0);
  endtask

  vec_t vecs[12];

  initial begin
    int lat, bcnt;

    vecs[0]  = '{8'hA5, SHL, 4'd3,  1'b0, 8'h28, 1'b1, 1'b1, 4};
    vecs[1]  = '{8'hA5, ROR, 4'd4,  1'b0, 8'h5A, 1'b1, 1'b0, 5};
    vecs[2]  = '{8'h5A, ROL, 4'd12, 1'b0, 8'h5A, 1'b1, 1'b0, 9};
    vecs[3]  = '{8'h96, ASR, 4'd2,  1'b0, 8'hE5, 1'b1, 1'b1, 3};
    vecs[4]  = '{8'hE5, SHR, 4'd1,  1'b1, 8'hF2, 1'b1, 1'b1, 2};
    vecs[5]  = '{8'hA5, SHL, 4'd0,  1'b0, 8'hA5, 1'b0, 1'b0, 1};
    vecs[6]  = '{8'h3C, HOLD, 4'd5, 1'b0, 8'h3C, 1'b0, 1'b0, 1};
    vecs[7]  = '{8'h3C, 3'd7, 4'd3, 1'b0, 8'h3C, 1'b0, 1'b0, 1};
    vecs[8]  = '{8'h81, SHL, 4'd8,  1'b1, 8'hFF, 1'b1, 1'b1, 9};
    vecs[9]  = '{8'h81, ASR, 4'd8,  1'b0, 8'hFF, 1'b1, 1'b1, 9};
    vecs[10] = '{8'h01, SHR, 4'd3,  1'b0, 8'h00, 1'b1, 1'b0, 4};
    vecs[11] = '{8'h80, ROL, 4'd1,  1'b0, 8'h01, 1'b1, 1'b1, 2};

    rst_n = 1'b0; clr = 1'b0; start = 1'b0; mode = HOLD;
    amount = '0; d = '0; sin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", {24'd0, q}, 32'h00);
    check("rst_sout", {31'd0, sout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      load(vecs[i].init_q);
      run_op(vecs[i].op, vecs[i].amt, vecs[i].s, 8'h00, 1'b0, lat, bcnt);
      check($sformatf("v%0d_q", i), {24'd0, q}, {24'd0, vecs[i].exp_q});
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].exp_lat - 1);
      if (vecs[i].chk_sout)
        check($sformatf("v%0d_sout", i), {31'd0, sout}, {31'd0, vecs[i].exp_sout});
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // sout holds through a LOAD (last shift above ejected 1).
    load(8'h00);
    check("sout_hold_load", {31'd0, sout}, 32'd1);

    // start while busy is ignored.
    load(8'hA5);
    run_op(SHL, 4'd3, 1'b0, 8'h00, 1'b1, lat, bcnt);
    check("busy_start_q", {24'd0, q}, 32'h28);
    check("busy_start_lat", lat, 4);
    @(posedge clk); #1;
    check("busy_start_no_load", {24'd0, q}, 32'h28);

    // Asynchronous reset in the middle of a 5-step shift.
    load(8'hA5);
    @(negedge clk);
    start = 1'b1; mode = SHL; amount = 4'd5; sin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_q", {24'd0, q}, 32'h00);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_sout", {31'd0, sout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_window("async_rst_no_done");

    // Synchronous clear in the middle of a 5-step shift.
    load(8'hA5);
    @(negedge clk);
    start = 1'b1; mode = SHL; amount = 4'd5; sin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    clr = 1'b1;
    #1;
    check("clr_pre_edge_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_q", {24'd0, q}, 32'h00);
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_sout", {31'd0, sout}, 32'd0);
    quiet_window("clr_no_done");

    // clr wins over a simultaneous start.
    load(8'h3C);
    @(negedge clk);
    start = 1'b1; clr = 1'b1; mode = LOAD; d = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0; clr = 1'b0;
    check("clr_prio_q", {24'd0, q}, 32'h00);
    check("clr_prio_done", {31'd0, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/param_shift_reg.md
Name: param_shift_reg

Overview:
- Parametrised universal shift register; the next generation of the single-bit DFF storage element.
- Holds a WIDTH-bit word with asynchronous active-low reset, synchronous clear and parallel load.
- Performs multi-cycle shift/rotate operations of a requested amount, one bit per cycle, with a start/busy/done handshake.
- Used as the shared datapath register for serial links and bit-manipulation units.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- RESET_VAL, {WIDTH{1'b0}}, value of q on reset and on clr.
- AMT_W, $clog2(WIDTH)+1, width of the amount input.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear; aborts any operation.
- start  input  1  operation request; sampled only in IDLE.
- mode  input  3  operation code (see package).
- amount  input  AMT_W  number of single-bit shifts.
- d  input  WIDTH  parallel load data.
- sin  input  1  serial fill bit for SHL/SHR, sampled every shift cycle.
- q  output  WIDTH  register contents.
- sout  output  1  bit ejected by the most recent shift/rotate.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - q=RESET_VAL, sout=0, busy=0, done=0, state=IDLE, internal count=0.
  - Any in-flight operation is lost; no done is produced.
- clr=1 at a clock edge: same effect as reset, applied synchronously. clr has priority over start.
- States: IDLE, SHIFT.
- IDLE, start=0: q holds; done=0.
- IDLE, start=1, mode=LOAD: q<=d on that edge; done=1 the following cycle; busy stays 0.
- IDLE, start=1, mode=HOLD, or any shift mode with amount=0: q unchanged; done=1 the following cycle.
- IDLE, start=1, shift mode, amount>0:
  - Latch mode and cnt=min(amount, WIDTH); amounts above WIDTH clamp to WIDTH.
  - Go to SHIFT; busy=1 from the next cycle.
- SHIFT, each cycle:
  - Perform one shift per the latched mode and decrement cnt.
  - On the edge where cnt goes 1->0: return to IDLE, busy=0, done=1, q final.
  - Latency from start edge to done high is amount+1 cycles.
- start while busy is ignored; mode, amount and d are don't-care in SHIFT.
- Shift semantics, one step:
  - SHL: q<={q[W-2:0],sin}, sout=q[W-1].
  - SHR: q<={sin,q[W-1:1]}, sout=q[0].
  - ROL: q<={q[W-2:0],q[W-1]}, sout=q[W-1].
  - ROR: q<={q[0],q[W-1:1]}, sout=q[0].
  - ASR: q<={q[W-1],q[W-1:1]}, sout=q[0].
- sout changes only on shift edges; it holds between operations and through LOAD.
- Reserved mode codes behave as HOLD.
- done is never high in the same cycle as busy.

Decomposition:
- Shared package shift_pkg holds:
  - mode encoding constants: HOLD=0, LOAD=1, SHL=2, SHR=3, ROL=4, ROR=5, ASR=6.
  - state typedef {IDLE, SHIFT}.
- One combinational sub-module, shift_step, computes next q and sout for one step given mode, q and sin.
- Counter and FSM stay in the top module.

Test Plan:
- WIDTH=8; LOAD d=8'hA5 -> q=8'hA5 after one edge; done pulse on the next cycle; busy never asserted.
- From q=8'hA5: SHL amount=3, sin=0 -> busy high for 3 cycles; done on cycle 4 after start; q=8'h28, sout=1.
- From q=8'hA5: ROR amount=4 -> q=8'h5A. Then ROL amount=12 (clamped to 8) -> done after 9 cycles with q=8'h5A unchanged.
- From q=8'h96: ASR amount=2 -> q=8'hE5, sout=1. Then SHR amount=1, sin=1 -> q=8'hF2, sout=1.
- Drop rst_n during SHIFT of a 5-step op -> q=RESET_VAL and busy=0 immediately; no done afterwards. Repeat with clr=1 -> same result one edge later.
- amount=0 with SHL -> done next cycle, q unchanged. start pulsed while busy -> ignored, original operation completes unaffected.
